snake_body_engine: RTL and testbench

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_next_head.sv | 26 ++
 rtl/snake_body_engine.sv | 131 +++++++++++++
 tb/tb_snake_body_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared grid dimensions, direction encodings and cell type for the snake
// engine and its system controller.
package snake_pkg;

  localparam int GRID_W    = 10;
  localparam int GRID_H    = 10;
  localparam int GRID_SIZE = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_t;

  // Opposite directions differ only in the MSB of the encoding.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head computation with toroidal wrap on both axes.
module snake_next_head #(
  parameter int COLS = snake_pkg::GRID_W,
  parameter int ROWS = snake_pkg::GRID_H
) (
  input  logic [3:0]       i_head_x,
  input  logic [3:0]       i_head_y,
  input  snake_pkg::dir_t  i_dir,
  output logic [3:0]       o_next_x,
  output logic [3:0]       o_next_y
);
  import snake_pkg::*;

  always_comb begin
    o_next_x = i_head_x;
    o_next_y = i_head_y;
    case (i_dir)
      DIR_UP:    o_next_y = (i_head_y == 4'd0) ? 4'(ROWS - 1) : i_head_y - 4'd1;
      DIR_DOWN:  o_next_y = (i_head_y == 4'(ROWS - 1)) ? 4'd0 : i_head_y + 4'd1;
      DIR_LEFT:  o_next_x = (i_head_x == 4'd0) ? 4'(COLS - 1) : i_head_x - 4'd1;
      DIR_RIGHT: o_next_x = (i_head_x == 4'(COLS - 1)) ? 4'd0 : i_head_x + 4'd1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store: shift-register of cells with head at entry 0, growth on
// food, sticky self-collision halt and a registered cell-occupancy lookup.
module snake_body_engine #(
  parameter int GRID_W   = snake_pkg::GRID_W,
  parameter int GRID_H   = snake_pkg::GRID_H,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       system_active,
  input  logic       reset_pulse,
  input  logic       step_tick,
  input  logic [1:0] dir_in,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  input  logic [3:0] query_x,
  input  logic [3:0] query_y,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [6:0] length,
  output logic [7:0] active_count,
  output logic       halt_condition,
  output logic       food_consumed,
  output logic       query_hit
);
  import snake_pkg::*;

  localparam int CELLS = GRID_W * GRID_H;

  cell_t      r_body [CELLS];
  dir_t       r_dir;
  logic [6:0] r_length;
  logic [7:0] r_active;
  logic       r_halt;
  logic       r_food;
  logic       r_query_hit;

  dir_t       w_dir_req;
  dir_t       w_dir_eff;
  cell_t      w_next;
  logic       w_move;
  logic       w_grow;
  logic       w_collide;
  logic       w_commit;
  logic [6:0] w_lim;
  logic [6:0] w_len_next;
  logic [CELLS-1:0] w_hit_vec;
  logic [CELLS-1:0] w_qry_vec;

  // Initial body lies horizontally to the left of (5,5); unused entries zeroed.
  function automatic cell_t init_cell(input int i);
    cell_t c;
    c = '0;
    if (i < INIT_LEN) begin
      c.x = 4'((5 - i + GRID_W * CELLS) % GRID_W);
      c.y = 4'd5;
    end
    return c;
  endfunction

  assign w_dir_req = dir_t'(dir_in);
  assign w_dir_eff = (w_dir_req == dir_opposite(r_dir)) ? r_dir : w_dir_req;
  assign w_move    = step_tick && system_active && !reset_pulse && !r_halt;

  snake_next_head #(
    .COLS (GRID_W),
    .ROWS (GRID_H)
  ) u_next_head (
    .i_head_x (r_body[0].x),
    .i_head_y (r_body[0].y),
    .i_dir    (w_dir_eff),
    .o_next_x (w_next.x),
    .o_next_y (w_next.y)
  );

  // Growth is ignored once the grid is full.
  assign w_grow = (w_next == {food_x, food_y}) && (r_length < 7'(CELLS));
  // The tail vacates on a plain move, so it is excluded from collision.
  assign w_lim  = w_grow ? r_length : r_length - 7'd1;

  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cmp
      assign w_hit_vec[gi] = (7'(gi) < w_lim)    && (r_body[gi] == w_next);
      assign w_qry_vec[gi] = (7'(gi) < r_length) && (r_body[gi] == {query_x, query_y});
    end
  endgenerate

  assign w_collide  = |w_hit_vec;
  assign w_commit   = w_move && !w_collide;
  assign w_len_next = w_grow ? r_length + 7'd1 : r_length;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) r_body[i] <= init_cell(i);
      r_dir       <= DIR_RIGHT;
      r_length    <= 7'(INIT_LEN);
      r_active    <= 8'(CELLS - INIT_LEN);
      r_halt      <= 1'b0;
      r_food      <= 1'b0;
      r_query_hit <= 1'b0;
    end else if (reset_pulse) begin
      for (int i = 0; i < CELLS; i++) r_body[i] <= init_cell(i);
      r_dir       <= DIR_RIGHT;
      r_length    <= 7'(INIT_LEN);
      r_active    <= 8'(CELLS - INIT_LEN);
      r_halt      <= 1'b0;
      r_food      <= 1'b0;
      r_query_hit <= 1'b0;
    end else begin
      r_query_hit <= |w_qry_vec;
      r_food      <= w_commit && w_grow;
      if (w_move && w_collide) r_halt <= 1'b1;
      if (w_commit) begin
        r_body[0] <= w_next;
        for (int i = 1; i < CELLS; i++) r_body[i] <= r_body[i-1];
        r_dir    <= w_dir_eff;
        r_length <= w_len_next;
        r_active <= 8'(CELLS) - {1'b0, w_len_next};
      end
    end
  end

  assign head_x         = r_body[0].x;
  assign head_y         = r_body[0].y;
  assign length         = r_length;
  assign active_count   = r_active;
  assign halt_condition = r_halt;
  assign food_consumed  = r_food;
  assign query_hit      = r_query_hit;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: each task drives one scenario and
// checks against hand-computed cells, lengths and flags.
module tb_snake_body_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       system_active;
  logic       reset_pulse;
  logic       step_tick;
  logic [1:0] dir_in;
  logic [3:0] food_x, food_y;
  logic [3:0] query_x, query_y;
  logic [3:0] head_x, head_y;
  logic [6:0] length;
  logic [7:0] active_count;
  logic       halt_condition;
  logic       food_consumed;
  logic       query_hit;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  snake_body_engine #(.GRID_W(10), .GRID_H(10), .INIT_LEN(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .system_active  (system_active),
    .reset_pulse    (reset_pulse),
    .step_tick      (step_tick),
    .dir_in         (dir_in),
    .food_x         (food_x),
    .food_y         (food_y),
    .query_x        (query_x),
    .query_y        (query_y),
    .head_x         (head_x),
    .head_y         (head_y),
    .length         (length),
    .active_count   (active_count),
    .halt_condition (halt_condition),
    .food_consumed  (food_consumed),
    .query_hit      (query_hit)
  );

  // One qualifying edge with the given direction; outputs sampled on the negedge after.
  task automatic do_step(input logic [1:0] d);
    @(negedge clk);
    dir_in    = d;
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
    $display("step dir=%0d -> head=(%0d,%0d) len=%0d free=%0d halt=%0b eat=%0b",
             d, head_x, head_y, length, active_count, halt_condition, food_consumed);
  endtask

  task automatic do_reset_pulse();
    @(negedge clk);
    reset_pulse = 1'b1;
    @(negedge clk);
    reset_pulse = 1'b0;
    $display("reset_pulse -> head=(%0d,%0d) len=%0d", head_x, head_y, length);
  endtask

  task automatic do_query(input logic [3:0] qx, input logic [3:0] qy);
    @(negedge clk);
    query_x = qx;
    query_y = qy;
    @(negedge clk);
    $display("query (%0d,%0d) -> hit=%0b", qx, qy, query_hit);
  endtask

  task automatic test_reset();
    n_total++;
    if ({head_x, head_y} !== {4'd5, 4'd5}) $display("FAIL reset_head got (%0d,%0d) want (5,5)", head_x, head_y);
    else n_pass++;
    n_total++;
    if (length !== 7'd3 || active_count !== 8'd97) $display("FAIL reset_len got len=%0d free=%0d want 3/97", length, active_count);
    else n_pass++;
    n_total++;
    if ({halt_condition, food_consumed, query_hit} !== 3'b000) $display("FAIL reset_flags got %b want 000", {halt_condition, food_consumed, query_hit});
    else n_pass++;
  endtask

  task automatic test_query_reset();
    do_query(4'd4, 4'd5);
    n_total++;
    if (query_hit !== 1'b1) $display("FAIL query_45 got %b want 1", query_hit); else n_pass++;
    do_query(4'd0, 4'd0);
    n_total++;
    if (query_hit !== 1'b0) $display("FAIL query_00 got %b want 0", query_hit); else n_pass++;
    do_query(4'd3, 4'd5);
    n_total++;
    if (query_hit !== 1'b1) $display("FAIL query_tail got %b want 1", query_hit); else n_pass++;
  endtask

  task automatic test_step();
    do_step(2'b01);
    n_total++;
    if ({head_x, head_y} !== {4'd6, 4'd5} || length !== 7'd3 || active_count !== 8'd97)
      $display("FAIL step_right got (%0d,%0d) len=%0d free=%0d want (6,5) 3/97", head_x, head_y, length, active_count);
    else n_pass++;
    do_query(4'd3, 4'd5);
    n_total++;
    if (query_hit !== 1'b0) $display("FAIL step_tail_gone got %b want 0", query_hit); else n_pass++;
    do_query(4'd4, 4'd5);
    n_total++;
    if (query_hit !== 1'b1) $display("FAIL step_new_tail got %b want 1", query_hit); else n_pass++;
  endtask

  task automatic test_no_move();
    system_active = 1'b0;
    do_step(2'b01);
    system_active = 1'b1;
    n_total++;
    if ({head_x, head_y} !== {4'd6, 4'd5}) $display("FAIL inactive_hold got (%0d,%0d) want (6,5)", head_x, head_y);
    else n_pass++;
    @(negedge clk);
    reset_pulse = 1'b1;
    do_step(2'b01);
    reset_pulse = 1'b0;
    n_total++;
    if ({head_x, head_y} !== {4'd5, 4'd5} || length !== 7'd3) $display("FAIL step_with_reset got (%0d,%0d) len=%0d want (5,5) 3", head_x, head_y, length);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset_pulse();
    for (int i = 0; i < 5; i++) do_step(2'b01);
    n_total++;
    if ({head_x, head_y} !== {4'd0, 4'd5}) $display("FAIL wrap_right got (%0d,%0d) want (0,5)", head_x, head_y);
    else n_pass++;
    do_reset_pulse();
    for (int i = 0; i < 6; i++) do_step(2'b00);
    n_total++;
    if ({head_x, head_y} !== {4'd5, 4'd9}) $display("FAIL wrap_up got (%0d,%0d) want (5,9)", head_x, head_y);
    else n_pass++;
  endtask

  task automatic test_grow();
    do_reset_pulse();
    food_x = 4'd6; food_y = 4'd5;
    do_step(2'b01);
    n_total++;
    if (length !== 7'd4 || active_count !== 8'd96) $display("FAIL grow_len got len=%0d free=%0d want 4/96", length, active_count);
    else n_pass++;
    n_total++;
    if (food_consumed !== 1'b1) $display("FAIL grow_pulse_hi got %b want 1", food_consumed); else n_pass++;
    food_x = 4'd0; food_y = 4'd0;
    @(negedge clk);
    n_total++;
    if (food_consumed !== 1'b0) $display("FAIL grow_pulse_lo got %b want 0", food_consumed); else n_pass++;
  endtask

  task automatic test_opposite();
    do_step(2'b11);
    n_total++;
    if ({head_x, head_y} !== {4'd7, 4'd5}) $display("FAIL opposite_kept got (%0d,%0d) want (7,5)", head_x, head_y);
    else n_pass++;
  endtask

  task automatic test_tail_chase();
    do_reset_pulse();
    food_x = 4'd6; food_y = 4'd5;
    do_step(2'b01);
    food_x = 4'd0; food_y = 4'd0;
    do_step(2'b10);
    do_step(2'b11);
    do_step(2'b00);
    n_total++;
    if (halt_condition !== 1'b0 || {head_x, head_y} !== {4'd5, 4'd5} || length !== 7'd4)
      $display("FAIL tail_chase got halt=%b (%0d,%0d) len=%0d want 0 (5,5) 4", halt_condition, head_x, head_y, length);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset_pulse();
    food_x = 4'd6; food_y = 4'd5;
    do_step(2'b01);
    food_x = 4'd7; food_y = 4'd5;
    do_step(2'b01);
    food_x = 4'd0; food_y = 4'd0;
    do_step(2'b10);
    do_step(2'b11);
    do_step(2'b00);
    n_total++;
    if (halt_condition !== 1'b1 || {head_x, head_y} !== {4'd6, 4'd6} || length !== 7'd5)
      $display("FAIL collide got halt=%b (%0d,%0d) len=%0d want 1 (6,6) 5", halt_condition, head_x, head_y, length);
    else n_pass++;
    do_step(2'b11);
    n_total++;
    if (halt_condition !== 1'b1 || {head_x, head_y} !== {4'd6, 4'd6})
      $display("FAIL halted_hold got halt=%b (%0d,%0d) want 1 (6,6)", halt_condition, head_x, head_y);
    else n_pass++;
    do_reset_pulse();
    n_total++;
    if (halt_condition !== 1'b0 || {head_x, head_y} !== {4'd5, 4'd5} || length !== 7'd3)
      $display("FAIL halt_clear got halt=%b (%0d,%0d) len=%0d want 0 (5,5) 3", halt_condition, head_x, head_y, length);
    else n_pass++;
  endtask

  initial begin
    rst_n         = 1'b0;
    system_active = 1'b1;
    reset_pulse   = 1'b0;
    step_tick     = 1'b0;
    dir_in        = 2'b01;
    food_x        = 4'd0;
    food_y        = 4'd0;
    query_x       = 4'd0;
    query_y       = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_query_reset();
    test_step();
    test_no_move();
    test_wrap();
    test_grow();
    test_opposite();
    test_tail_chase();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
